// File: rtl/nios_ii_nios2_qsys_0_oci_dct_packer.sv
// Packs 2-bit trace symbols into 15-symbol trace words, with flush and
// end-of-test drain handling and a single-entry valid/ready output register.
module nios_ii_nios2_qsys_0_oci_dct_packer (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        dct_in_valid,
    input  logic [1:0]  dct_in_data,
    output logic        dct_in_ready,
    input  logic        flush,
    input  logic        test_ending,
    output logic [29:0] dct_buffer,
    output logic [3:0]  dct_count,
    output logic        tw_valid,
    input  logic        tw_ready,
    output logic [33:0] tw_data,
    output logic        overflow,
    output logic        test_has_ended
);

    localparam int unsigned SYM_W    = 2;
    localparam int unsigned BUF_W    = 30;
    localparam int unsigned CNT_W    = 4;
    localparam int unsigned MAX_SYMS = 15;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        DRAIN = 2'd1,
        ENDED = 2'd2
    } state_t;

    state_t state;
    logic   flush_pending;
    logic   in_run;
    logic   out_free;
    logic   buf_full;
    logic   buf_empty;
    logic   transfer;
    logic   accept;
    logic   drain_done;

    assign in_run     = (state == RUN);
    assign out_free   = !tw_valid || tw_ready;
    assign buf_full   = (dct_count == CNT_W'(MAX_SYMS));
    assign buf_empty  = (dct_count == '0);
    assign drain_done = (state == DRAIN) && buf_empty && !tw_valid;

    // A full buffer always ships; a partial one ships when flushed or draining.
    assign transfer = reset_n && out_free && (state != ENDED) &&
                      (buf_full || ((flush_pending || state == DRAIN) && !buf_empty));

    // Input side sees the slot freed by a same-cycle transfer.
    assign dct_in_ready = reset_n && in_run && (!buf_full || transfer);
    assign accept       = dct_in_valid && dct_in_ready;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state          <= RUN;
            dct_buffer     <= '0;
            dct_count      <= '0;
            tw_valid       <= 1'b0;
            tw_data        <= '0;
            overflow       <= 1'b0;
            test_has_ended <= 1'b0;
            flush_pending  <= 1'b0;
        end else begin
            if (transfer) begin
                tw_data  <= {dct_count, dct_buffer};
                tw_valid <= 1'b1;
            end else if (tw_valid && tw_ready) begin
                tw_valid <= 1'b0;
            end

            if (transfer && accept) begin
                dct_buffer <= BUF_W'(dct_in_data);
                dct_count  <= CNT_W'(1);
            end else if (transfer) begin
                dct_buffer <= '0;
                dct_count  <= '0;
            end else if (accept) begin
                dct_buffer <= {dct_buffer[BUF_W-SYM_W-1:0], dct_in_data};
                dct_count  <= dct_count + CNT_W'(1);
            end

            if (in_run && dct_in_valid && !dct_in_ready) begin
                overflow <= 1'b1;
            end

            // test_ending outranks flush; an empty buffer never produces a word.
            if (!in_run || test_ending) begin
                flush_pending <= 1'b0;
            end else if (flush) begin
                flush_pending <= 1'b1;
            end else if (transfer || buf_empty) begin
                flush_pending <= 1'b0;
            end

            case (state)
                RUN:     if (test_ending) state <= DRAIN;
                DRAIN:   if (drain_done) state <= ENDED;
                ENDED:   state <= ENDED;
                default: state <= RUN;
            endcase

            test_has_ended <= (state == ENDED) || drain_done;
        end
    end

endmodule

// File: tb/tb_nios_ii_nios2_qsys_0_oci_dct_packer.sv
// Directed bench for the trace symbol packer: a per-cycle vector table plus
// hand-written sequences for full-buffer, backpressure, drain and reset cases.
module tb_nios_ii_nios2_qsys_0_oci_dct_packer;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        dct_in_valid = 1'b0;
    logic [1:0]  dct_in_data = 2'd0;
    logic        dct_in_ready;
    logic        flush = 1'b0;
    logic        test_ending = 1'b0;
    logic [29:0] dct_buffer;
    logic [3:0]  dct_count;
    logic        tw_valid;
    logic        tw_ready = 1'b0;
    logic [33:0] tw_data;
    logic        overflow;
    logic        test_has_ended;

    int n_vec = 0;
    int n_err = 0;

    nios_ii_nios2_qsys_0_oci_dct_packer dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .dct_in_valid   (dct_in_valid),
        .dct_in_data    (dct_in_data),
        .dct_in_ready   (dct_in_ready),
        .flush          (flush),
        .test_ending    (test_ending),
        .dct_buffer     (dct_buffer),
        .dct_count      (dct_count),
        .tw_valid       (tw_valid),
        .tw_ready       (tw_ready),
        .tw_data        (tw_data),
        .overflow       (overflow),
        .test_has_ended (test_has_ended)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        v;
        logic [1:0]  d;
        logic        fl;
        logic        te;
        logic        rdy;
        logic        e_ir;
        logic [3:0]  e_cnt;
        logic [29:0] e_buf;
        logic        e_tv;
        logic [33:0] e_td;
        logic        e_ov;
        logic        e_end;
    } vec_t;

    localparam int unsigned NVEC = 20;
    localparam logic [33:0] W1 = 34'h0C0000039;
    localparam logic [33:0] W2 = 34'h040000001;
    localparam logic [33:0] W3 = 34'h040000002;
    localparam logic [33:0] WF1 = 34'h3D5555555;
    localparam logic [33:0] WF2 = 34'h3EAAAAAAA;

    vec_t tbl [NVEC];
    logic [1:0] syms [5];

    task automatic drive(input logic v, input logic [1:0] d, input logic fl,
                         input logic te, input logic rdy);
        dct_in_valid = v;
        dct_in_data  = d;
        flush        = fl;
        test_ending  = te;
        tw_ready     = rdy;
    endtask

    task automatic tick;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic chk(input string nm, input logic [33:0] act, input logic [33:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic [3:0] cnt, input logic [29:0] b,
                           input logic tv, input logic [33:0] td, input logic ov,
                           input logic en);
        chk({tag, ".cnt"}, 34'(dct_count), 34'(cnt));
        chk({tag, ".buf"}, 34'(dct_buffer), 34'(b));
        chk({tag, ".tv"},  34'(tw_valid), 34'(tv));
        chk({tag, ".td"},  tw_data, td);
        chk({tag, ".ov"},  34'(overflow), 34'(ov));
        chk({tag, ".end"}, 34'(test_has_ended), 34'(en));
    endtask

    task automatic do_reset;
        reset_n = 1'b0;
        drive(1'b0, 2'd0, 1'b0, 1'b0, 1'b0);
        tick;
        tick;
        reset_n = 1'b1;
    endtask

    initial begin
        // flush path, empty flush, backpressure, drain and ended behaviour
        tbl[0]  = '{1'b1, 2'd3, 1'b0, 1'b0, 1'b1, 1'b1, 4'd1, 30'h3,  1'b0, 34'h0, 1'b0, 1'b0};
        tbl[1]  = '{1'b1, 2'd2, 1'b0, 1'b0, 1'b1, 1'b1, 4'd2, 30'hE,  1'b0, 34'h0, 1'b0, 1'b0};
        tbl[2]  = '{1'b1, 2'd1, 1'b0, 1'b0, 1'b1, 1'b1, 4'd3, 30'h39, 1'b0, 34'h0, 1'b0, 1'b0};
        tbl[3]  = '{1'b0, 2'd0, 1'b1, 1'b0, 1'b1, 1'b1, 4'd3, 30'h39, 1'b0, 34'h0, 1'b0, 1'b0};
        tbl[4]  = '{1'b0, 2'd0, 1'b0, 1'b0, 1'b1, 1'b1, 4'd0, 30'h0,  1'b1, W1,    1'b0, 1'b0};
        tbl[5]  = '{1'b0, 2'd0, 1'b0, 1'b0, 1'b1, 1'b1, 4'd0, 30'h0,  1'b0, W1,    1'b0, 1'b0};
        tbl[6]  = '{1'b0, 2'd0, 1'b1, 1'b0, 1'b1, 1'b1, 4'd0, 30'h0,  1'b0, W1,    1'b0, 1'b0};
        tbl[7]  = '{1'b0, 2'd0, 1'b0, 1'b0, 1'b1, 1'b1, 4'd0, 30'h0,  1'b0, W1,    1'b0, 1'b0};
        tbl[8]  = '{1'b0, 2'd0, 1'b0, 1'b0, 1'b1, 1'b1, 4'd0, 30'h0,  1'b0, W1,    1'b0, 1'b0};
        tbl[9]  = '{1'b1, 2'd1, 1'b0, 1'b0, 1'b1, 1'b1, 4'd1, 30'h1,  1'b0, W1,    1'b0, 1'b0};
        tbl[10] = '{1'b0, 2'd0, 1'b1, 1'b0, 1'b1, 1'b1, 4'd1, 30'h1,  1'b0, W1,    1'b0, 1'b0};
        tbl[11] = '{1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b1, 4'd0, 30'h0,  1'b1, W2,    1'b0, 1'b0};
        tbl[12] = '{1'b1, 2'd2, 1'b0, 1'b0, 1'b0, 1'b1, 4'd1, 30'h2,  1'b1, W2,    1'b0, 1'b0};
        tbl[13] = '{1'b0, 2'd0, 1'b0, 1'b0, 1'b1, 1'b1, 4'd1, 30'h2,  1'b0, W2,    1'b0, 1'b0};
        tbl[14] = '{1'b0, 2'd0, 1'b1, 1'b1, 1'b1, 1'b1, 4'd1, 30'h2,  1'b0, W2,    1'b0, 1'b0};
        tbl[15] = '{1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 30'h0,  1'b1, W3,    1'b0, 1'b0};
        tbl[16] = '{1'b1, 2'd3, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 30'h0,  1'b1, W3,    1'b0, 1'b0};
        tbl[17] = '{1'b0, 2'd0, 1'b0, 1'b0, 1'b1, 1'b0, 4'd0, 30'h0,  1'b0, W3,    1'b0, 1'b0};
        tbl[18] = '{1'b0, 2'd0, 1'b0, 1'b0, 1'b1, 1'b0, 4'd0, 30'h0,  1'b0, W3,    1'b0, 1'b1};
        tbl[19] = '{1'b1, 2'd1, 1'b1, 1'b1, 1'b1, 1'b0, 4'd0, 30'h0,  1'b0, W3,    1'b0, 1'b1};

        // reset state
        reset_n = 1'b0;
        drive(1'b0, 2'd0, 1'b0, 1'b0, 1'b0);
        tick;
        #1 chk("rst.ready", 34'(dct_in_ready), 34'(1'b0));
        tick;
        chk_all("rst", 4'd0, 30'h0, 1'b0, 34'h0, 1'b0, 1'b0);
        reset_n = 1'b1;
        #1 chk("rst.ready_after", 34'(dct_in_ready), 34'(1'b1));

        for (int i = 0; i < int'(NVEC); i++) begin
            drive(tbl[i].v, tbl[i].d, tbl[i].fl, tbl[i].te, tbl[i].rdy);
            #1 chk($sformatf("vec%0d.ready", i), 34'(dct_in_ready), 34'(tbl[i].e_ir));
            tick;
            chk_all($sformatf("vec%0d", i), tbl[i].e_cnt, tbl[i].e_buf, tbl[i].e_tv,
                    tbl[i].e_td, tbl[i].e_ov, tbl[i].e_end);
        end

        // 15 symbols of 01 fill the buffer, next cycle ships the word
        do_reset;
        drive(1'b1, 2'd1, 1'b0, 1'b0, 1'b1);
        repeat (15) tick;
        chk_all("full15", 4'd15, 30'h15555555, 1'b0, 34'h0, 1'b0, 1'b0);
        drive(1'b0, 2'd0, 1'b0, 1'b0, 1'b1);
        #1 chk("full15.ready", 34'(dct_in_ready), 34'(1'b1));
        tick;
        chk_all("full15.word", 4'd0, 30'h0, 1'b1, WF1, 1'b0, 1'b0);

        // stall sink and stream 31 symbols: the 31st is dropped
        do_reset;
        drive(1'b1, 2'd1, 1'b0, 1'b0, 1'b0);
        repeat (15) tick;
        drive(1'b1, 2'd2, 1'b0, 1'b0, 1'b0);
        #1 chk("ovf.ready16", 34'(dct_in_ready), 34'(1'b1));
        tick;
        chk_all("ovf.s16", 4'd1, 30'h2, 1'b1, WF1, 1'b0, 1'b0);
        repeat (14) tick;
        chk_all("ovf.s30", 4'd15, 30'h2AAAAAAA, 1'b1, WF1, 1'b0, 1'b0);
        drive(1'b1, 2'd3, 1'b0, 1'b0, 1'b0);
        #1 chk("ovf.ready31", 34'(dct_in_ready), 34'(1'b0));
        tick;
        chk_all("ovf.s31", 4'd15, 30'h2AAAAAAA, 1'b1, WF1, 1'b1, 1'b0);
        drive(1'b0, 2'd0, 1'b0, 1'b0, 1'b0);
        tick;
        chk("ovf.sticky", 34'(overflow), 34'(1'b1));

        // 16th symbol arrives as the sink frees the register
        do_reset;
        drive(1'b1, 2'd1, 1'b0, 1'b0, 1'b0);
        repeat (15) tick;
        drive(1'b0, 2'd0, 1'b0, 1'b0, 1'b0);
        tick;
        drive(1'b1, 2'd2, 1'b0, 1'b0, 1'b0);
        repeat (15) tick;
        drive(1'b0, 2'd0, 1'b0, 1'b0, 1'b0);
        #1 chk("free16.ready_stalled", 34'(dct_in_ready), 34'(1'b0));
        drive(1'b1, 2'd3, 1'b0, 1'b0, 1'b1);
        #1 chk("free16.ready", 34'(dct_in_ready), 34'(1'b1));
        tick;
        chk_all("free16", 4'd1, 30'h3, 1'b1, WF2, 1'b0, 1'b0);

        // drain with a held word, then end of test
        do_reset;
        syms[0] = 2'd1; syms[1] = 2'd2; syms[2] = 2'd3; syms[3] = 2'd0; syms[4] = 2'd1;
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, syms[i], 1'b0, 1'b0, 1'b1);
            tick;
        end
        chk_all("drain.fill", 4'd5, 30'h1B1, 1'b0, 34'h0, 1'b0, 1'b0);
        drive(1'b0, 2'd0, 1'b0, 1'b1, 1'b0);
        tick;
        drive(1'b0, 2'd0, 1'b0, 1'b0, 1'b0);
        #1 chk("drain.ready", 34'(dct_in_ready), 34'(1'b0));
        tick;
        chk_all("drain.word", 4'd0, 30'h0, 1'b1, 34'h1400001B1, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            tick;
            chk_all($sformatf("drain.hold%0d", i), 4'd0, 30'h0, 1'b1, 34'h1400001B1, 1'b0, 1'b0);
        end
        drive(1'b0, 2'd0, 1'b0, 1'b0, 1'b1);
        tick;
        chk_all("drain.taken", 4'd0, 30'h0, 1'b0, 34'h1400001B1, 1'b0, 1'b0);
        tick;
        chk("drain.ended", 34'(test_has_ended), 34'(1'b1));
        tick;
        chk("drain.ended_hold", 34'(test_has_ended), 34'(1'b1));

        // reset mid-drain discards the pending word
        do_reset;
        drive(1'b1, 2'd3, 1'b0, 1'b0, 1'b1);
        tick;
        tick;
        drive(1'b0, 2'd0, 1'b0, 1'b1, 1'b0);
        tick;
        drive(1'b0, 2'd0, 1'b0, 1'b0, 1'b0);
        tick;
        chk_all("mid.word", 4'd0, 30'h0, 1'b1, 34'h08000000F, 1'b0, 1'b0);
        reset_n = 1'b0;
        #1 chk("mid.ready_rst", 34'(dct_in_ready), 34'(1'b0));
        tick;
        chk_all("mid.rst", 4'd0, 30'h0, 1'b0, 34'h0, 1'b0, 1'b0);
        reset_n = 1'b1;
        drive(1'b1, 2'd2, 1'b0, 1'b0, 1'b1);
        #1 chk("mid.ready_rel", 34'(dct_in_ready), 34'(1'b1));
        tick;
        chk_all("mid.resume", 4'd1, 30'h2, 1'b0, 34'h0, 1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/nios_ii_nios2_qsys_0_oci_dct_packer.md
NIOS_II_NIOS2_QSYS_0_OCI_DCT_PACKER -- requirements
Module: nios_ii_nios2_qsys_0_oci_dct_packer

Interface
REQ-001 SHALL have one clock and a synchronous, active-low reset: clk in, reset_n in.
REQ-002 SHALL have port clk, input, 1 bit: sole clock, rising edge.
REQ-003 SHALL have port reset_n, input, 1 bit: synchronous active-low reset.
REQ-004 SHALL have port dct_in_valid, input, 1 bit: trace symbol present this cycle.
REQ-005 SHALL have port dct_in_data, input, 2 bits: trace symbol.
REQ-006 SHALL have port dct_in_ready, output, 1 bit: symbol accepted this cycle when high with dct_in_valid.
REQ-007 SHALL have port flush, input, 1 bit: single-cycle request to emit the partial buffer.
REQ-008 SHALL have port test_ending, input, 1 bit: single-cycle request for final drain.
REQ-009 SHALL have port dct_buffer, output, 30 bits: live packing buffer.
REQ-010 SHALL have port dct_count, output, 4 bits: number of symbols in dct_buffer, 0..15.
REQ-011 SHALL have port tw_valid, output, 1 bit: trace word available.
REQ-012 SHALL have port tw_ready, input, 1 bit: sink accepts the trace word.
REQ-013 SHALL have port tw_data, output, 34 bits: {count[3:0], buffer[29:0]}.
REQ-014 SHALL have port overflow, output, 1 bit: sticky flag, a symbol was dropped.
REQ-015 SHALL have port test_has_ended, output, 1 bit: drain complete.

Function
REQ-016 SHALL run a state machine with states RUN, DRAIN and ENDED.
REQ-017 On accept (dct_in_valid & dct_in_ready), dct_buffer SHALL take {dct_buffer[27:0], dct_in_data} and dct_count SHALL increment, visible the next cycle.
REQ-018 Data SHALL be right-justified: the newest symbol is in [1:0]; with count k, bits [29:2k] are zero.
REQ-019 dct_in_ready SHALL be 1 only in RUN with dct_count < 15, or in RUN when a transfer occurs this cycle.
REQ-020 The output register SHALL be free when tw_valid=0, or when tw_valid=1 and tw_ready=1.
REQ-021 A transfer SHALL occur when the output register is free and either dct_count==15 or flush_pending=1 with dct_count>0.
REQ-022 On a transfer, tw_data SHALL take {dct_count, dct_buffer} and tw_valid SHALL be 1 on the next cycle.
REQ-023 On a transfer with a simultaneous accept, the buffer SHALL become {28'b0, dct_in_data} and dct_count SHALL become 1.
REQ-024 On a transfer without an accept, the buffer and dct_count SHALL clear to 0.
REQ-025 tw_data and tw_valid SHALL be held stable while tw_valid=1 and tw_ready=0.
REQ-026 When the sink takes the word (tw_valid & tw_ready) and no new transfer occurs, tw_valid SHALL be 0 on the next cycle.
REQ-027 A flush pulse SHALL set flush_pending.
REQ-028 flush_pending SHALL clear on the next transfer.
REQ-029 flush_pending SHALL clear immediately if dct_count==0, and no empty word SHALL be emitted.
REQ-030 A flush pulse during an existing pending flush SHALL be absorbed.
REQ-031 When dct_in_valid=1 and dct_in_ready=0 in RUN, the symbol SHALL be dropped and overflow SHALL set.
REQ-032 overflow SHALL stay set until reset.
REQ-033 A test_ending pulse in RUN SHALL move the machine to DRAIN.
REQ-034 In DRAIN, dct_in_ready SHALL be 0, inputs SHALL be ignored, and overflow SHALL not set.
REQ-035 In DRAIN, a partial buffer with dct_count>0 SHALL transfer as if flushed.
REQ-036 The machine SHALL go from DRAIN to ENDED when dct_count==0 and tw_valid==0.
REQ-037 In ENDED, test_has_ended SHALL be 1 and hold until reset; all inputs except reset_n SHALL be ignored.
REQ-038 When test_ending and flush arrive in the same cycle, test_ending SHALL take priority.
REQ-039 When test_ending arrives in DRAIN or ENDED, it SHALL be ignored.

Reset
REQ-040 While reset_n=0 at a rising edge, the block SHALL set state=RUN, dct_buffer=0, dct_count=0, tw_valid=0, tw_data=0, overflow=0, test_has_ended=0, flush_pending=0.
REQ-041 Reset SHALL take effect at the next edge regardless of state.
REQ-042 A word pending on tw_data during reset SHALL be discarded.
REQ-043 dct_in_ready SHALL be 0 during reset and 1 in the first cycle after release.

Verification
REQ-044 Scenario: 15 consecutive symbols 2'b01 with tw_ready=1 -> one cycle after the 15th accept, tw_valid=1, tw_data={4'hF, 30'h15555555}, dct_count=0.
REQ-045 Scenario: 3 symbols 3,2,1 then flush -> tw_data={4'd3, 30'h39}, tw_valid=1 exactly one word; a second flush with count 0 -> no word.
REQ-046 Scenario: tw_ready=0, stream 31 symbols -> word 1 held stable, buffer fills to 15, dct_in_ready=0, the 31st symbol is dropped, overflow=1.
REQ-047 Scenario: 16th symbol in the same cycle tw_ready frees the register -> transfer of 15 symbols plus dct_count=1 holding the new symbol, no overflow.
REQ-048 Scenario: 5 symbols then test_ending with tw_ready=0 for 4 cycles -> state DRAIN, word {5, ...} held; after tw_ready=1 -> test_has_ended=1 on the cycle after tw_valid drops.
REQ-049 Scenario: reset_n=0 asserted mid-DRAIN with tw_valid=1 -> all outputs at reset values on the next edge; normal packing resumes after release.
